// File: rtl/psum_drain_if.sv
// Stream bundle between the bottom PE row, the drain stage and the writeback path.
// The slave side is the drain stage itself; the master side feeds the lanes and takes the beats.
interface psum_drain_if #(
  parameter int outputBits = 32
);
  logic                  in_valid;
  logic                  in_last;
  logic [outputBits-1:0] s;
  logic [outputBits-1:0] t;
  logic [outputBits-1:0] u;
  logic [outputBits-1:0] v;
  logic [outputBits-1:0] out_data;
  logic [1:0]            out_lane;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_valid, in_last, s, t, u, v, out_ready,
    input  out_data, out_lane, out_valid
  );

  modport slave (
    input  in_valid, in_last, s, t, u, v, out_ready,
    output out_data, out_lane, out_valid
  );
endinterface

// File: rtl/psum_drain.sv
// Accumulates the four partial-sum lanes across K-tiles, queues each finished vector,
// and serialises it one lane per beat onto a valid/ready stream for writeback.
module psum_drain #(
  parameter int outputBits = 32,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  psum_drain_if.slave            bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] COUNT_ONE  = (AW+1)'(1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state;
  state_t                state_next;
  logic [outputBits-1:0] acc     [4];
  logic [outputBits-1:0] lane_in [4];
  logic [outputBits-1:0] sum     [4];
  logic [outputBits-1:0] mem     [DEPTH][4];
  logic                  first;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [1:0]            lane;
  logic [AW:0]           count_next;
  logic                  push_req;
  logic                  push;
  logic                  accept;
  logic                  pop;

  assign lane_in[0] = bus.s;
  assign lane_in[1] = bus.t;
  assign lane_in[2] = bus.u;
  assign lane_in[3] = bus.v;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sum[i] = (first ? '0 : acc[i]) + lane_in[i];
    end
  end

  // Admission looks only at the registered count, so a full FIFO rejects even while popping.
  assign push_req = bus.in_valid && bus.in_last;
  assign push     = push_req && (fifo_count < FULL_COUNT);
  assign accept   = (state == SEND) && bus.out_ready;
  assign pop      = accept && (lane == 2'd3);

  always_comb begin
    count_next = fifo_count;
    if (push && !pop) begin
      count_next = fifo_count + COUNT_ONE;
    end else if (pop && !push) begin
      count_next = fifo_count - COUNT_ONE;
    end
  end

  // Looking at the post-update count lets a fresh push start sending on the very next cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (count_next != '0) state_next = SEND;
      SEND:    if (pop) state_next = (count_next != '0) ? SEND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.out_valid = (state == SEND);
  assign bus.out_lane  = lane;
  assign bus.out_data  = mem[rd_ptr][lane];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first      <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lane       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc[i] <= '0;
      end
      for (int e = 0; e < DEPTH; e++) begin
        for (int i = 0; i < 4; i++) begin
          mem[e][i] <= '0;
        end
      end
    end else begin
      fifo_count <= count_next;
      if (bus.in_valid) begin
        first <= bus.in_last;
        if (!bus.in_last) begin
          for (int i = 0; i < 4; i++) begin
            acc[i] <= sum[i];
          end
        end
      end
      if (push) begin
        for (int i = 0; i < 4; i++) begin
          mem[wr_ptr][i] <= sum[i];
        end
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (push_req && !push) begin
        overflow <= 1'b1;
      end
      if (accept) begin
        lane <= lane + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: stimulus queues hand-computed beats, and an
// independent monitor pops and compares every beat the DUT hands over.
module tb_psum_drain;
  typedef struct packed {
    logic [1:0]  lane;
    logic [31:0] data;
  } beat_t;

  logic       clk;
  logic       rst;
  logic [2:0] fifo_count;
  logic       overflow;
  int         errors;
  int         checks;
  beat_t      sb[$];
  beat_t      mon_exp;

  psum_drain_if #(.outputBits(32)) bus ();

  psum_drain #(
    .outputBits(32),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushResult(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
    sb.push_back('{lane: 2'd0, data: d0});
    sb.push_back('{lane: 2'd1, data: d1});
    sb.push_back('{lane: 2'd2, data: d2});
    sb.push_back('{lane: 2'd3, data: d3});
  endtask

  task automatic applyStimulus(input logic last, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.s = a;
    bus.t = b;
    bus.u = c;
    bus.v = d;
    tick(1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // Scoreboard side: every accepted beat must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat: got lane=%0d data=%h, required no beat", bus.out_lane, bus.out_data);
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("beat_lane", 32'(bus.out_lane), 32'(mon_exp.lane));
        checkOutput("beat_data", bus.out_data, mon_exp.data);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.s = '0;
    bus.t = '0;
    bus.u = '0;
    bus.v = '0;
    bus.out_ready = 1'b1;
    tick(2);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_lane", 32'(bus.out_lane), 32'd0);
    checkOutput("rst_out_data", bus.out_data, 32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick(1);

    $display("[TB] single-beat result");
    pushResult(32'd1, 32'd2, 32'd3, 32'd4);
    applyStimulus(1'b1, 32'd1, 32'd2, 32'd3, 32'd4);
    checkOutput("single_latency_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("single_latency_lane", 32'(bus.out_lane), 32'd0);
    tick(4);
    checkOutput("single_done_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("single_done_count", 32'(fifo_count), 32'd0);

    $display("[TB] accumulation and wrap");
    pushResult(32'd60, 32'hFFFF_FFFE, 32'h0000_0001, 32'd0);
    applyStimulus(1'b0, 32'd10, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'd0);
    applyStimulus(1'b0, 32'd20, 32'd0, 32'd0, 32'd0);
    applyStimulus(1'b1, 32'd30, 32'd3, 32'd2, 32'd0);
    tick(4);
    pushResult(32'd7, 32'd0, 32'd0, 32'd0);
    applyStimulus(1'b1, 32'd7, 32'd0, 32'd0, 32'd0);
    tick(4);
    checkOutput("accum_done_count", 32'(fifo_count), 32'd0);

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    pushResult(32'd9, 32'd0, 32'd0, 32'd0);
    applyStimulus(1'b1, 32'd9, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("hold_lane", 32'(bus.out_lane), 32'd0);
      checkOutput("hold_data", bus.out_data, 32'd9);
      tick(1);
    end
    bus.out_ready = 1'b1;
    tick(1);
    checkOutput("release_lane", 32'(bus.out_lane), 32'd1);
    tick(3);
    checkOutput("release_done_count", 32'(fifo_count), 32'd0);

    $display("[TB] overflow");
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) pushResult(32'(k), 32'd0, 32'd0, 32'd0);
      applyStimulus(1'b1, 32'(k), 32'd0, 32'd0, 32'd0);
    end
    checkOutput("ovf_count", 32'(fifo_count), 32'd4);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    bus.out_ready = 1'b1;
    tick(16);
    checkOutput("ovf_drain_count", 32'(fifo_count), 32'd0);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    $display("[TB] full push+pop collision");
    doReset();
    checkOutput("coll_rst_overflow", 32'(overflow), 32'd0);
    bus.out_ready = 1'b0;
    for (int k = 11; k <= 14; k++) begin
      pushResult(32'(k), 32'd0, 32'd0, 32'd0);
      applyStimulus(1'b1, 32'(k), 32'd0, 32'd0, 32'd0);
    end
    checkOutput("coll_full_count", 32'(fifo_count), 32'd4);
    checkOutput("coll_full_overflow", 32'(overflow), 32'd0);
    bus.out_ready = 1'b1;
    tick(3);
    checkOutput("coll_lane3", 32'(bus.out_lane), 32'd3);
    applyStimulus(1'b1, 32'd99, 32'd98, 32'd97, 32'd96);
    checkOutput("coll_count", 32'(fifo_count), 32'd3);
    checkOutput("coll_overflow", 32'(overflow), 32'd1);
    checkOutput("coll_next_lane", 32'(bus.out_lane), 32'd0);
    tick(12);
    checkOutput("coll_drain_count", 32'(fifo_count), 32'd0);

    $display("[TB] reset mid-drain");
    pushResult(32'd5, 32'd6, 32'd7, 32'd8);
    applyStimulus(1'b1, 32'd5, 32'd6, 32'd7, 32'd8);
    applyStimulus(1'b0, 32'd100, 32'd100, 32'd100, 32'd100);
    tick(1);
    checkOutput("mid_lane_before_rst", 32'(bus.out_lane), 32'd2);
    doReset();
    sb.delete();
    checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_count", 32'(fifo_count), 32'd0);
    checkOutput("mid_rst_lane", 32'(bus.out_lane), 32'd0);
    checkOutput("mid_rst_overflow", 32'(overflow), 32'd0);
    pushResult(32'd1, 32'd2, 32'd3, 32'd4);
    applyStimulus(1'b1, 32'd1, 32'd2, 32'd3, 32'd4);
    tick(5);
    checkOutput("mid_done_count", 32'(fifo_count), 32'd0);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
